// File: rtl/ipgu.sv
// ipgu -- image pyramid generation unit.
// Holds a 300x300 image in ram1. It walks the pyramid levels 300, 240, 180,
// 120, 60 and 20, and streams every 20x20 window of each level, stride 10,
// to a consumer through a valid/ready handshake. Between levels the current
// image is downscaled into the other RAM (ping-pong). Each window is read
// one 20-pixel row per cycle. Each downscale takes one clear cycle plus one
// cycle per source row.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   csRam1_ext            external chip-select of ram1; freezes the block that cycle
//   weRam1_ext            external write-enable (reserved, not acted on)
//   initIpgu              start pulse, sampled in IDLE
//   rdyIpgu               1 when idle or when the pyramid is complete
//   wrAll / wrAllData     bulk load of the full image into ram1 (IDLE only)
//   rdyHeu                consumer accepts the current window
//   vldIpgu               ipguOutBufferQ holds a valid window
//   ipguOutBufferQ        20x20 window, 5 rows of 80 pixels (4 image rows each)

package ipguPkg;
  localparam int IMG = 300;
  localparam int WIN = 20;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    WAIT_HEU = 3'd2,
    SCALE    = 3'd3,
    DONE     = 3'd4
  } ipguState_e;

  // Edge length of pyramid level l.
  function automatic int lvlSize(input int l);
    case (l)
      0:       return 300;
      1:       return 240;
      2:       return 180;
      3:       return 120;
      4:       return 60;
      default: return 20;
    endcase
  endfunction

  // Downscaling level t into level t+1: destination column x ends up holding
  // the last source column j with floor(j*n/d) == x, i.e. ceil((x+1)*d/n)-1.
  function automatic int colMap(input int t, input int x);
    int d;
    int n;
    d = lvlSize(t);
    n = lvlSize(t + 1);
    if (x >= n) return 0;
    return ((x + 1) * d + n - 1) / n - 1;
  endfunction
endpackage

// Image RAM. Each address is one full 300-pixel row. The RAM supports a
// one-cycle clear, a one-cycle bulk load and a one-row write. Reads are
// combinational.
module ipguRam import ipguPkg::*; #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          wrAll,
  input  logic [IMG-1:0][IMG-1:0][DW-1:0] wrAllData,
  input  logic                          wrEn,
  input  logic [AW-1:0]                 wrAddr,
  input  logic [IMG-1:0][DW-1:0]        wrData,
  input  logic [AW-1:0]                 rdAddr,
  output logic [IMG-1:0][DW-1:0]        rdData
);
  logic [IMG-1:0][DW-1:0] mem [IMG];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int r = 0; r < IMG; r++) mem[r] <= '0;
    end else if (wrAll) begin
      for (int r = 0; r < IMG; r++) mem[r] <= wrAllData[r];
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];
endmodule

// Control FSM with the window, level and downscale counters.
module ipguCtrl import ipguPkg::*; #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          initIpgu,
  input  logic          rdyHeu,
  output ipguState_e    state,
  output logic [2:0]    level,
  output logic [AW-1:0] top,
  output logic [AW-1:0] left,
  output logic [4:0]    fillCnt,
  output logic [AW-1:0] srcRow,
  output logic [AW-1:0] dstRow,
  output logic          scaleClr,
  output logic          rdyIpgu,
  output logic          vldIpgu
);
  logic [AW-1:0] d, n, acc;
  logic [AW:0]   accSum;

  assign d = AW'(lvlSize(int'(level)));
  assign n = AW'(lvlSize(int'(level) + 1));
  // acc holds srcRow*n mod d, so dstRow tracks floor(srcRow*n/d) without a divider.
  assign accSum = {1'b0, acc} + {1'b0, n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      level    <= '0;
      top      <= '0;
      left     <= '0;
      fillCnt  <= '0;
      srcRow   <= '0;
      dstRow   <= '0;
      acc      <= '0;
      scaleClr <= 1'b0;
      rdyIpgu  <= 1'b1;
      vldIpgu  <= 1'b0;
    end else if (!stall) begin
      case (state)
        IDLE: if (initIpgu) begin
          level   <= '0;
          top     <= '0;
          left    <= '0;
          fillCnt <= '0;
          rdyIpgu <= 1'b0;
          state   <= FILL;
        end
        FILL: begin
          if (fillCnt == 5'(WIN - 1)) begin
            fillCnt <= '0;
            vldIpgu <= 1'b1;
            state   <= WAIT_HEU;
          end else begin
            fillCnt <= fillCnt + 5'd1;
          end
        end
        WAIT_HEU: if (rdyHeu) begin
          vldIpgu <= 1'b0;
          if (left != d - AW'(WIN)) begin
            left  <= left + AW'(10);
            state <= FILL;
          end else if (top != d - AW'(WIN)) begin
            left  <= '0;
            top   <= top + AW'(10);
            state <= FILL;
          end else if (level == 3'd5) begin
            rdyIpgu <= 1'b1;
            state   <= DONE;
          end else begin
            scaleClr <= 1'b1;
            srcRow   <= '0;
            dstRow   <= '0;
            acc      <= '0;
            state    <= SCALE;
          end
        end
        SCALE: begin
          // First cycle clears the destination RAM; then one source row per cycle.
          if (scaleClr) begin
            scaleClr <= 1'b0;
          end else if (srcRow == d - AW'(1)) begin
            level   <= level + 3'd1;
            top     <= '0;
            left    <= '0;
            fillCnt <= '0;
            state   <= FILL;
          end else begin
            srcRow <= srcRow + AW'(1);
            if (accSum >= {1'b0, d}) begin
              acc    <= AW'(accSum - {1'b0, d});
              dstRow <= dstRow + AW'(1);
            end else begin
              acc <= AW'(accSum);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module ipgu import ipguPkg::*; #(
  parameter int RAM_DATA_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = $clog2(300) * 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      csRam1_ext,
  input  logic                                      weRam1_ext,
  input  logic                                      initIpgu,
  output logic                                      rdyIpgu,
  input  logic                                      wrAll,
  input  logic [IMG-1:0][IMG-1:0][RAM_DATA_WIDTH-1:0] wrAllData,
  input  logic                                      rdyHeu,
  output logic                                      vldIpgu,
  output logic [4:0][79:0][RAM_DATA_WIDTH-1:0]      ipguOutBufferQ
);
  localparam int AW = RAM_ADDR_WIDTH / 2;

  ipguState_e    state;
  logic [2:0]    level;
  logic [AW-1:0] top, left, srcRow, dstRow, rdRow;
  logic [4:0]    fillCnt;
  logic          scaleClr, stall;
  logic          scaleEn, clrEn, rowEn, wrAll1;
  logic [IMG-1:0][RAM_DATA_WIDTH-1:0] row1, row2, srcData, scaleRow;
  // Window as 20 image rows of 20 pixels; this is bit-identical to the
  // 5x80 output packing (row r=4i+j lands at [i][j*20 +: 20]).
  logic [WIN-1:0][WIN-1:0][RAM_DATA_WIDTH-1:0] winBuf;

  // External ram1 writes are reserved; the block does not act on them.
  wire unusedWeExt = weRam1_ext;

  assign stall = csRam1_ext;

  ipguCtrl #(.AW(AW)) ctrlUnit (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .initIpgu (initIpgu),
    .rdyHeu   (rdyHeu),
    .state    (state),
    .level    (level),
    .top      (top),
    .left     (left),
    .fillCnt  (fillCnt),
    .srcRow   (srcRow),
    .dstRow   (dstRow),
    .scaleClr (scaleClr),
    .rdyIpgu  (rdyIpgu),
    .vldIpgu  (vldIpgu)
  );

  // Even levels live in ram1 and odd levels in ram2; the scale writes the other RAM.
  assign rdRow   = (state == SCALE) ? srcRow : top + AW'(fillCnt);
  assign srcData = level[0] ? row2 : row1;
  assign scaleEn = !stall && (state == SCALE);
  assign clrEn   = scaleEn && scaleClr;
  assign rowEn   = scaleEn && !scaleClr;
  assign wrAll1  = !stall && (state == IDLE) && wrAll;

  // Column remap of one source row into its destination row, per level transition.
  for (genvar x = 0; x < IMG; x++) begin : gColMap
    localparam logic [AW-1:0] M0 = AW'(colMap(0, x));
    localparam logic [AW-1:0] M1 = AW'(colMap(1, x));
    localparam logic [AW-1:0] M2 = AW'(colMap(2, x));
    localparam logic [AW-1:0] M3 = AW'(colMap(3, x));
    localparam logic [AW-1:0] M4 = AW'(colMap(4, x));
    logic [RAM_DATA_WIDTH-1:0] px;
    always_comb begin
      px = '0;
      case (level)
        3'd0: if (x < lvlSize(1)) px = srcData[M0];
        3'd1: if (x < lvlSize(2)) px = srcData[M1];
        3'd2: if (x < lvlSize(3)) px = srcData[M2];
        3'd3: if (x < lvlSize(4)) px = srcData[M3];
        3'd4: if (x < lvlSize(5)) px = srcData[M4];
        default: px = '0;
      endcase
    end
    assign scaleRow[x] = px;
  end

  ipguRam #(.DW(RAM_DATA_WIDTH), .AW(AW)) ram1 (
    .clk       (clk),
    .clr       (clrEn && level[0]),
    .wrAll     (wrAll1),
    .wrAllData (wrAllData),
    .wrEn      (rowEn && level[0]),
    .wrAddr    (dstRow),
    .wrData    (scaleRow),
    .rdAddr    (rdRow),
    .rdData    (row1)
  );

  ipguRam #(.DW(RAM_DATA_WIDTH), .AW(AW)) ram2 (
    .clk       (clk),
    .clr       (clrEn && !level[0]),
    .wrAll     (1'b0),
    .wrAllData ('0),
    .wrEn      (rowEn && !level[0]),
    .wrAddr    (dstRow),
    .wrData    (scaleRow),
    .rdAddr    (rdRow),
    .rdData    (row2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) winBuf <= '0;
    else if (!stall && state == FILL) winBuf[fillCnt] <= srcData[left +: WIN];
  end

  assign ipguOutBufferQ = winBuf;
endmodule

// File: tb/tb_ipgu.sv
// Self-checking bench for ipgu. A reference model keeps the current pyramid
// level as a plain 2-D array. It downscales with the literal
// dest[i*n/d][j*n/d] = src[i][j] loop and builds expected windows from the
// row/column packing formula.
module tb_ipgu;
  typedef logic [4:0][79:0][7:0] win_t;

  logic clk = 1'b0, rst_n = 1'b1;
  logic csRam1_ext = 1'b0, weRam1_ext = 1'b0, initIpgu = 1'b0, wrAll = 1'b0, rdyHeu = 1'b0;
  logic rdyIpgu, vldIpgu;
  logic [299:0][299:0][7:0] wrAllData;
  win_t ipguOutBufferQ;

  ipgu dut (
    .clk(clk), .rst_n(rst_n), .csRam1_ext(csRam1_ext), .weRam1_ext(weRam1_ext),
    .initIpgu(initIpgu), .rdyIpgu(rdyIpgu), .wrAll(wrAll), .wrAllData(wrAllData),
    .rdyHeu(rdyHeu), .vldIpgu(vldIpgu), .ipguOutBufferQ(ipguOutBufferQ)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  logic [7:0] img [300][300];
  logic [7:0] orig [300][300];
  logic [7:0] tmp [300][300];
  bit csRand = 0;
  int sizes [6] = '{300, 240, 180, 120, 60, 20};

  // Random external chip-select stalls while enabled.
  initial forever begin
    @(posedge clk); #1;
    csRam1_ext = csRand && ($urandom_range(0, 15) == 0);
  end

  initial begin
    #950000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic win_t expWin(input int top, input int left);
    win_t e;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 4; j++)
        for (int c = 0; c < 20; c++)
          e[i][j*20+c] = img[top+4*i+j][left+c];
    return e;
  endfunction

  function automatic int firstDiff(input win_t a, input win_t b);
    for (int p = 0; p < 400; p++) if (a[p/80][p%80] !== b[p/80][p%80]) return p;
    return 0;
  endfunction

  task automatic scaleModel(input int d, input int n);
    for (int i = 0; i < 300; i++) for (int j = 0; j < 300; j++) tmp[i][j] = 8'd0;
    for (int i = 0; i < d; i++) for (int j = 0; j < d; j++) tmp[i*n/d][j*n/d] = img[i][j];
    img = tmp;
  endtask

  task automatic loadImage(input bit ramp);
    for (int i = 0; i < 300; i++)
      for (int j = 0; j < 300; j++) begin
        img[i][j] = ramp ? 8'((i + j) % 256) : 8'($urandom_range(0, 255));
        wrAllData[i][j] = img[i][j];
      end
    wrAll = 1'b1; @(posedge clk); #1; wrAll = 1'b0;
  endtask

  task automatic pulseInit();
    initIpgu = 1'b1; @(posedge clk); #1; initIpgu = 1'b0;
  endtask

  task automatic waitVld(input int budget, output bit ok);
    int n = 0;
    while (vldIpgu !== 1'b1 && n < budget) begin @(posedge clk); #1; n++; end
    ok = (vldIpgu === 1'b1);
  endtask

  task automatic consume(output bit ok);
    int n = 0;
    rdyHeu = 1'b1;
    do begin @(posedge clk); #1; n++; end while (vldIpgu === 1'b1 && n < 100);
    rdyHeu = 1'b0;
    ok = (vldIpgu === 1'b0);
  endtask

  task automatic test_reset();
    total++; if (rdyIpgu !== 1'b1) $display("FAIL reset_rdy got %b want 1", rdyIpgu); else passed++;
    total++; if (vldIpgu !== 1'b0) $display("FAIL reset_vld got %b want 0", vldIpgu); else passed++;
    total++; if (ipguOutBufferQ !== '0) $display("FAIL reset_buf got nonzero want 0"); else passed++;
    total++; if (dut.ctrlUnit.state !== 3'd0) $display("FAIL reset_state got %0d want 0", dut.ctrlUnit.state); else passed++;
  endtask

  // Ramp image: windows 0..28 of level 300, with a 100-cycle hold on window 0.
  task automatic test_ramp_hold();
    bit ok, same;
    int p;
    win_t e;
    loadImage(1'b1);
    pulseInit();
    for (int w = 0; w < 29; w++) begin
      waitVld(200, ok);
      total++; if (!ok) begin $display("FAIL ramp_vld_timeout win %0d got vld %b want 1", w, vldIpgu); return; end else passed++;
      e = expWin((w / 29) * 10, (w % 29) * 10);
      total++;
      if (ipguOutBufferQ !== e) begin
        p = firstDiff(ipguOutBufferQ, e);
        $display("FAIL ramp_win %0d pixel %0d got %h want %h", w, p, ipguOutBufferQ[p/80][p%80], e[p/80][p%80]);
      end else passed++;
      if (w == 0) begin
        total++; if (ipguOutBufferQ[4][79] !== 8'd38) $display("FAIL ramp_corner got %0d want 38", ipguOutBufferQ[4][79]); else passed++;
        total++; if (rdyIpgu !== 1'b0) $display("FAIL busy_rdy got %b want 0", rdyIpgu); else passed++;
        same = 1;
        repeat (100) begin
          @(posedge clk); #1;
          if (ipguOutBufferQ !== e || vldIpgu !== 1'b1) same = 0;
        end
        total++; if (!same) $display("FAIL hold_stable got changed want stable"); else passed++;
        total++; if (dut.ctrlUnit.state !== 3'd2) $display("FAIL hold_state got %0d want 2", dut.ctrlUnit.state); else passed++;
      end
      consume(ok);
      total++; if (!ok) $display("FAIL ramp_consume win %0d got vld %b want 0", w, vldIpgu); else passed++;
    end
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
  endtask

  // Run into level 240, then reset asynchronously and restart from ram1.
  task automatic test_abort();
    bit ok;
    int p;
    logic [7:0] v11;
    win_t e;
    loadImage(1'b0);
    orig = img;
    pulseInit();
    for (int w = 0; w < 841; w++) begin
      waitVld(200, ok);
      total++; if (!ok) begin $display("FAIL abort_vld_timeout win %0d got vld %b want 1", w, vldIpgu); return; end else passed++;
      e = expWin((w / 29) * 10, (w % 29) * 10);
      total++;
      if (ipguOutBufferQ !== e) begin
        p = firstDiff(ipguOutBufferQ, e);
        $display("FAIL l300_win %0d pixel %0d got %h want %h", w, p, ipguOutBufferQ[p/80][p%80], e[p/80][p%80]);
      end else passed++;
      consume(ok);
      total++; if (!ok) $display("FAIL abort_consume win %0d got vld %b want 0", w, vldIpgu); else passed++;
    end
    v11 = img[1][1];
    scaleModel(300, 240);
    waitVld(800, ok);
    total++; if (!ok) begin $display("FAIL l240_vld_timeout got vld %b want 1", vldIpgu); return; end else passed++;
    e = expWin(0, 0);
    total++;
    if (ipguOutBufferQ !== e) begin
      p = firstDiff(ipguOutBufferQ, e);
      $display("FAIL l240_win0 pixel %0d got %h want %h", p, ipguOutBufferQ[p/80][p%80], e[p/80][p%80]);
    end else passed++;
    total++; if (ipguOutBufferQ[0][0] !== v11) $display("FAIL l240_px00 got %h want %h", ipguOutBufferQ[0][0], v11); else passed++;
    // Asynchronous reset mid-cycle while a window is being offered.
    #2 rst_n = 1'b0;
    #1;
    total++; if (vldIpgu !== 1'b0) $display("FAIL abort_vld got %b want 0", vldIpgu); else passed++;
    total++; if (rdyIpgu !== 1'b1) $display("FAIL abort_rdy got %b want 1", rdyIpgu); else passed++;
    total++; if (ipguOutBufferQ !== '0) $display("FAIL abort_buf got nonzero want 0"); else passed++;
    total++; if (dut.ctrlUnit.state !== 3'd0) $display("FAIL abort_state got %0d want 0", dut.ctrlUnit.state); else passed++;
    @(posedge clk); #1; rst_n = 1'b1;
    img = orig;
    pulseInit();
    waitVld(200, ok);
    total++; if (!ok) begin $display("FAIL restart_vld_timeout got vld %b want 1", vldIpgu); return; end else passed++;
    e = expWin(0, 0);
    total++;
    if (ipguOutBufferQ !== e) begin
      p = firstDiff(ipguOutBufferQ, e);
      $display("FAIL restart_win0 pixel %0d got %h want %h", p, ipguOutBufferQ[p/80][p%80], e[p/80][p%80]);
    end else passed++;
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
  endtask

  // Complete pyramid with random stalls and consumer delays.
  task automatic test_full_run();
    bit ok;
    int p, d, k;
    win_t e;
    loadImage(1'b0);
    pulseInit();
    csRand = 1;
    for (int lvl = 0; lvl < 6; lvl++) begin
      d = sizes[lvl];
      k = d / 10 - 1;
      for (int w = 0; w < k * k; w++) begin
        waitVld(800, ok);
        total++;
        if (!ok) begin
          $display("FAIL full_vld_timeout lvl %0d win %0d got vld %b want 1", d, w, vldIpgu);
          csRand = 0; csRam1_ext = 1'b0;
          return;
        end else passed++;
        e = expWin((w / k) * 10, (w % k) * 10);
        total++;
        if (ipguOutBufferQ !== e) begin
          p = firstDiff(ipguOutBufferQ, e);
          $display("FAIL full_win lvl %0d win %0d pixel %0d got %h want %h", d, w, p, ipguOutBufferQ[p/80][p%80], e[p/80][p%80]);
        end else passed++;
        if (lvl == 0 && w == 3) begin
          // init and bulk load while busy must be ignored.
          wrAllData = '1;
          wrAll = 1'b1; initIpgu = 1'b1;
          @(posedge clk); #1;
          wrAll = 1'b0; initIpgu = 1'b0;
          total++; if (vldIpgu !== 1'b1 || ipguOutBufferQ !== e) $display("FAIL busy_ignore got vld %b want 1 and unchanged buffer", vldIpgu); else passed++;
        end
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        consume(ok);
        total++; if (!ok) $display("FAIL full_consume lvl %0d win %0d got vld %b want 0", d, w, vldIpgu); else passed++;
      end
      if (lvl < 5) scaleModel(d, sizes[lvl + 1]);
    end
    csRand = 0; csRam1_ext = 1'b0;
    total++; if (rdyIpgu !== 1'b1) $display("FAIL done_rdy got %b want 1", rdyIpgu); else passed++;
    repeat (30) begin @(posedge clk); #1; end
    total++; if (vldIpgu !== 1'b0) $display("FAIL extra_window got vld %b want 0", vldIpgu); else passed++;
    total++; if (dut.ctrlUnit.state !== 3'd0 || rdyIpgu !== 1'b1) $display("FAIL end_idle got state %0d rdy %b want 0 1", dut.ctrlUnit.state, rdyIpgu); else passed++;
  endtask

  initial begin
    wrAllData = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_ramp_hold();
    test_abort();
    test_full_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
